// File: rtl/multi_queue_fifo.sv
// -----------------------------------------------------------------------------
// multi_queue_fifo
//
// Multi-lane circular instruction queue between fetch and decode. Each cycle
// it accepts up to CHANNEL contiguous entries from the push vector, starting
// at a lane offset. It retires up to pop_num entries from the head. The oldest
// CHANNEL entries are always presented combinationally, with a valid mask.
//
// Ports:
//   clk          rising-edge clock
//   rst_n        synchronous active-low reset (priority over flush)
//   flush        empties the queue next cycle (overrides push, pop, stall)
//   stall        when 1, no entries are retired
//   full         fewer than CHANNEL free entries (advisory)
//   empty        queue holds zero entries
//   data_push    CHANNEL push lanes, lane i = data_push[i*DATA_WIDTH +: DATA_WIDTH]
//   push_num     number of entries to push (0..CHANNEL)
//   push_offset  first push lane to take
//   data_pop     lane i = i-th oldest entry
//   pop_valid    bit i set iff the queue holds more than i entries
//   pop_num      number of head entries to retire
// -----------------------------------------------------------------------------
module multi_queue_fifo #(
   parameter int DATA_WIDTH = 32,
   parameter int DEPTH      = 4,
   parameter int CHANNEL    = 4
) (
   input  logic                            clk,
   input  logic                            rst_n,
   input  logic                            flush,
   input  logic                            stall,
   output logic                            full,
   output logic                            empty,
   input  logic [CHANNEL*DATA_WIDTH-1:0]   data_push,
   input  logic [$clog2(CHANNEL+1)-1:0]    push_num,
   input  logic [$clog2(CHANNEL):0]        push_offset,
   output logic [CHANNEL*DATA_WIDTH-1:0]   data_pop,
   output logic [CHANNEL-1:0]              pop_valid,
   input  logic [$clog2(CHANNEL+1)-1:0]    pop_num
);

   localparam int CAP   = DEPTH * CHANNEL;
   localparam int PTR_W = $clog2(CAP);
   localparam int CNT_W = $clog2(CAP + 1);

   // Pointers are plain PTR_W-bit counters; because CAP is a power of two
   // their natural wrap is exactly the modulo-CAP behaviour we need.
   logic [DATA_WIDTH-1:0] r_mem [CAP];
   logic [PTR_W-1:0]      r_head;
   logic [PTR_W-1:0]      r_tail;
   logic [CNT_W-1:0]      r_count;

   logic [CNT_W-1:0]      w_eff_pop;
   logic [CNT_W-1:0]      w_eff_push;
   logic [CNT_W-1:0]      w_lane_room;
   logic [CNT_W-1:0]      w_space;
   logic [DATA_WIDTH-1:0] w_push_lane [CHANNEL];
   logic [DATA_WIDTH-1:0] w_wr_data   [CHANNEL];
   logic [PTR_W-1:0]      w_wr_addr   [CHANNEL];
   logic [CHANNEL-1:0]    w_wr_en;

   // ------------------------------------------------------------------------
   // Effective pop / push amounts
   // ------------------------------------------------------------------------
   always_comb begin
      // NOTE: every comb output gets a default first so no path leaves it
      // unassigned, which would otherwise infer a latch.
      w_eff_pop   = '0;
      w_eff_push  = '0;
      w_lane_room = '0;
      w_space     = '0;

      if (!flush && !stall) begin
         w_eff_pop = (CNT_W'(pop_num) < r_count) ? CNT_W'(pop_num) : r_count;
      end

      // Lanes past the end of the push vector are never taken, so an offset
      // at or beyond CHANNEL pushes nothing.
      if (int'(push_offset) < CHANNEL) begin
         w_lane_room = CNT_W'(CHANNEL - int'(push_offset));
      end

      // Space freed by this cycle's pop is usable by this cycle's push.
      w_space = CNT_W'(CAP) - r_count + w_eff_pop;

      if (!flush) begin
         w_eff_push = CNT_W'(push_num);
         if (w_lane_room < w_eff_push) w_eff_push = w_lane_room;
         if (w_space < w_eff_push)     w_eff_push = w_space;
      end
   end

   // ------------------------------------------------------------------------
   // Push lane steering: write slot k takes lane push_offset+k
   // ------------------------------------------------------------------------
   always_comb begin
      for (int j = 0; j < CHANNEL; j++) begin
         w_push_lane[j] = data_push[j*DATA_WIDTH +: DATA_WIDTH];
      end
      for (int k = 0; k < CHANNEL; k++) begin
         w_wr_data[k] = '0;
         for (int j = 0; j < CHANNEL; j++) begin
            if (int'(push_offset) + k == j) w_wr_data[k] = w_push_lane[j];
         end
         w_wr_addr[k] = r_tail + PTR_W'(k);
         // Only slots within eff_push are written, so dropped overflow never
         // overwrites live entries at the head.
         w_wr_en[k]   = rst_n && (CNT_W'(k) < w_eff_push);
      end
   end

   // ------------------------------------------------------------------------
   // Control state
   // ------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments so every flop
      // samples the pre-edge values, independent of statement order.
      if (!rst_n) begin
         r_head  <= '0;
         r_tail  <= '0;
         r_count <= '0;
      end else if (flush) begin
         r_head  <= '0;
         r_tail  <= '0;
         r_count <= '0;
      end else begin
         r_head  <= r_head + PTR_W'(w_eff_pop);
         r_tail  <= r_tail + PTR_W'(w_eff_push);
         r_count <= r_count + w_eff_push - w_eff_pop;
      end
   end

   // ------------------------------------------------------------------------
   // Entry storage
   // ------------------------------------------------------------------------
   // NOTE: storage is deliberately not reset; entries outside the valid
   // window are don't-care, and leaving them unreset keeps this a plain RAM.
   always_ff @(posedge clk) begin
      for (int k = 0; k < CHANNEL; k++) begin
         if (w_wr_en[k]) r_mem[w_wr_addr[k]] <= w_wr_data[k];
      end
   end

   // ------------------------------------------------------------------------
   // Outputs: zero-latency view of the oldest CHANNEL entries
   // ------------------------------------------------------------------------
   always_comb begin
      for (int i = 0; i < CHANNEL; i++) begin
         data_pop[i*DATA_WIDTH +: DATA_WIDTH] = r_mem[r_head + PTR_W'(i)];
         pop_valid[i] = (r_count > CNT_W'(i));
      end
   end

   assign empty = (r_count == '0);
   assign full  = ((CNT_W'(CAP) - r_count) < CNT_W'(CHANNEL));

endmodule

// File: tb/tb_multi_queue_fifo.sv
// -----------------------------------------------------------------------------
// tb_multi_queue_fifo
//
// Scoreboard bench for multi_queue_fifo (DATA_WIDTH=8, DEPTH=2, CHANNEL=4).
// The driver applies one cycle of stimulus, advances a queue-based reference
// model and pushes the expected post-edge outputs into a scoreboard; a
// separate monitor pops one expectation after every clock edge and compares.
// -----------------------------------------------------------------------------
module tb_multi_queue_fifo;

   localparam int DW    = 8;
   localparam int DEPTH = 2;
   localparam int CH    = 4;
   localparam int CAP   = DEPTH * CH;

   logic           clk = 1'b0;
   logic           rst_n = 1'b0;
   logic           flush = 1'b0;
   logic           stall = 1'b0;
   logic           full;
   logic           empty;
   logic [CH*DW-1:0] data_push = '0;
   logic [2:0]     push_num = '0;
   logic [2:0]     push_offset = '0;
   logic [CH*DW-1:0] data_pop;
   logic [CH-1:0]  pop_valid;
   logic [2:0]     pop_num = '0;

   always #5 clk = ~clk;

   multi_queue_fifo #(
      .DATA_WIDTH (DW),
      .DEPTH      (DEPTH),
      .CHANNEL    (CH)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .flush       (flush),
      .stall       (stall),
      .full        (full),
      .empty       (empty),
      .data_push   (data_push),
      .push_num    (push_num),
      .push_offset (push_offset),
      .data_pop    (data_pop),
      .pop_valid   (pop_valid),
      .pop_num     (pop_num)
   );

   typedef struct packed {
      logic             empty;
      logic             full;
      logic [CH-1:0]    valid;
      logic [CH*DW-1:0] data;
   } exp_t;

   exp_t           sb[$];
   logic [DW-1:0]  model_q[$];
   int             total = 0;
   int             bad   = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // One cycle of stimulus plus the reference-model update for that edge.
   task automatic step(input logic rn, input logic fl, input logic st,
                       input int pnum, input int poff, input int ppop,
                       input logic [CH*DW-1:0] d);
      exp_t e;
      int   npop;
      @(posedge clk);
      #2;
      rst_n       = rn;
      flush       = fl;
      stall       = st;
      push_num    = pnum[2:0];
      push_offset = poff[2:0];
      pop_num     = ppop[2:0];
      data_push   = d;

      if (!rn || fl) begin
         model_q.delete();
      end else begin
         npop = st ? 0 : ((ppop < model_q.size()) ? ppop : model_q.size());
         repeat (npop) void'(model_q.pop_front());
         // Contiguous lanes from the offset, stopping at the vector end or
         // when the queue is full; the rest is dropped.
         for (int k = 0; k < pnum; k++) begin
            if (poff + k < CH && model_q.size() < CAP)
               model_q.push_back(d[(poff+k)*DW +: DW]);
         end
      end

      e.empty = (model_q.size() == 0);
      e.full  = ((CAP - model_q.size()) < CH);
      e.valid = '0;
      e.data  = '0;
      for (int i = 0; i < CH; i++) begin
         if (i < model_q.size()) begin
            e.valid[i]        = 1'b1;
            e.data[i*DW +: DW] = model_q[i];
         end
      end
      sb.push_back(e);
   endtask

   // Monitor: after every edge, compare the DUT against the oldest expectation.
   initial begin
      exp_t e;
      forever begin
         @(posedge clk);
         #1;
         if (sb.size() > 0) begin
            e = sb.pop_front();
            check("empty", 32'(empty), 32'(e.empty));
            check("full",  32'(full),  32'(e.full));
            check("pop_valid", 32'(pop_valid), 32'(e.valid));
            for (int i = 0; i < CH; i++) begin
               if (e.valid[i])
                  check($sformatf("data_pop[%0d]", i),
                        32'(data_pop[i*DW +: DW]), 32'(e.data[i*DW +: DW]));
            end
         end
      end
   end

   localparam logic [CH*DW-1:0] D1 = {8'd4, 8'd3, 8'd2, 8'd1};
   localparam logic [CH*DW-1:0] D2 = {8'h44, 8'h33, 8'h22, 8'h11};
   localparam logic [CH*DW-1:0] D3 = {8'h88, 8'h77, 8'h66, 8'h55};

   initial begin
      logic [CH*DW-1:0] rd;
      // Reset
      step(0, 0, 0, 0, 0, 0, D1);
      step(0, 0, 0, 0, 0, 0, D1);
      // Fill with offsets, reaching full, then drain across the wrap
      step(1, 0, 0, 1, 2, 0, D1);
      step(1, 0, 0, 2, 0, 0, D1);
      step(1, 0, 0, 3, 0, 0, D1);
      step(1, 0, 0, 2, 0, 0, D1);
      step(1, 0, 0, 0, 0, 3, D1);
      step(1, 0, 0, 0, 0, 1, D1);
      step(1, 0, 0, 0, 0, 2, D1);
      step(1, 0, 0, 0, 0, 2, D1);
      // Offset beyond the vector pushes nothing
      step(1, 0, 0, 4, 5, 0, D1);
      step(1, 0, 0, 4, 4, 0, D1);
      // Overflow: count 6 plus push 4 keeps only 2
      step(1, 0, 0, 3, 0, 0, D2);
      step(1, 0, 0, 3, 1, 0, D3);
      step(1, 0, 0, 4, 0, 0, D1);
      // Pop clamping: count 2 with pop 4
      step(1, 0, 0, 0, 0, 4, D1);
      step(1, 0, 0, 0, 0, 2, D1);
      step(1, 0, 0, 0, 0, 4, D1);
      step(1, 0, 0, 0, 0, 0, D1);
      // Simultaneous push/pop at count 8
      step(1, 0, 0, 4, 0, 0, D2);
      step(1, 0, 0, 4, 0, 0, D3);
      step(1, 0, 0, 4, 0, 4, D1);
      // Stall blocks pop while push proceeds
      step(1, 0, 0, 0, 0, 4, D1);
      step(1, 0, 1, 2, 1, 4, D2);
      step(1, 0, 0, 0, 0, 0, D1);
      // Flush with concurrent push and pop
      step(1, 1, 0, 4, 0, 2, D3);
      step(1, 0, 0, 0, 0, 0, D1);

      // Randomized traffic
      for (int n = 0; n < 400; n++) begin
         rd = {$urandom, $urandom};
         step(($urandom_range(0, 99) != 0),
              ($urandom_range(0, 31) == 0),
              ($urandom_range(0, 7) == 0),
              int'($urandom_range(0, CH)),
              int'($urandom_range(0, 7)),
              int'($urandom_range(0, CH)),
              rd);
      end

      // Let the monitor consume the final expectation.
      @(posedge clk);
      #3;
      check("scoreboard_drained", 32'(sb.size()), 32'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
